// File: rtl/mul_add_rr_sched.sv
// Round-robin scheduler sharing one unsigned multiply-add datapath
// (P = X*Y + A) between several requesters, with a single-entry registered
// response buffer that refills in the same cycle it drains.
//
// Output buffer FSM
//   state    | meaning
//   ST_EMPTY | no response held, rsp_valid_o low
//   ST_FULL  | a response is held on rsp_p_o/rsp_id_o, rsp_valid_o high

module mul_add_uns #(
    parameter int WidthX = 8,
    parameter int WidthY = 8,
    parameter int WidthA = 20,
    parameter int Speed  = 1
) (
    input  logic [WidthX-1:0] x,
    input  logic [WidthY-1:0] y,
    input  logic [WidthA-1:0] a,
    output logic [WidthA-1:0] p
);
    localparam int WidthP = WidthX + WidthY;

    logic [WidthP-1:0] prod;

    if (Speed == 0) begin : g_slow
        // Shift-and-add over the narrower operand, one partial product per bit.
        always_comb begin
            prod = '0;
            for (int i = 0; i < WidthX; i++) begin
                if (x[i]) prod = prod + (WidthP'(y) << i);
            end
        end
    end else if (Speed >= 2 && WidthX >= 2) begin : g_fast
        localparam int HalfX = WidthX / 2;
        logic [HalfX-1:0]        x_lo;
        logic [WidthX-HalfX-1:0] x_hi;
        // Two narrower multipliers summed, shortening the carry chains.
        always_comb begin
            x_lo = x[HalfX-1:0];
            x_hi = x[WidthX-1:HalfX];
            prod = ((WidthP'(x_hi) * WidthP'(y)) << HalfX)
                 + (WidthP'(x_lo) * WidthP'(y));
        end
    end else begin : g_med
        // Let synthesis pick the multiplier architecture.
        always_comb begin
            prod = WidthP'(x) * WidthP'(y);
        end
    end

    // Sum wraps modulo 2^WidthA; the carry-out is dropped.
    always_comb begin
        p = WidthA'(prod) + a;
    end
endmodule

module mul_add_rr_sched #(
    parameter int NumReq  = 4,
    parameter int WidthX  = 8,
    parameter int WidthY  = 8,
    parameter int WidthA  = 20,
    parameter int Speed   = 1,
    parameter int IdWidth = (NumReq > 2) ? $clog2(NumReq) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic [NumReq*WidthX-1:0]  req_x_i,
    input  logic [NumReq*WidthY-1:0]  req_y_i,
    input  logic [NumReq*WidthA-1:0]  req_a_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [WidthA-1:0]         rsp_p_o,
    output logic [IdWidth-1:0]        rsp_id_o,
    output logic                      busy_o,
    output logic [31:0]               issue_cnt_o
);
    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             state_q, state_d;
    logic [IdWidth-1:0] ptr_q;
    logic [IdWidth-1:0] ptr_d;
    logic [NumReq-1:0]  grant;
    logic [IdWidth-1:0] gidx;
    logic               found;
    logic               issue_en;
    logic               issue;
    int                 idx;
    logic [WidthX-1:0]  x_sel;
    logic [WidthY-1:0]  y_sel;
    logic [WidthA-1:0]  a_sel;
    logic [WidthA-1:0]  p_sel;

    assign rsp_valid_o = (state_q == ST_FULL);
    assign issue_en    = !rsp_valid_o || rsp_ready_i;
    assign req_ready_o = issue_en ? grant : '0;
    assign issue       = |req_ready_o;
    assign busy_o      = rsp_valid_o || (|req_valid_i);

    // Priority search starting at ptr, wrapping; first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!found && req_valid_i[IdWidth'(idx)]) begin
                found                 = 1'b1;
                grant[IdWidth'(idx)]  = 1'b1;
                gidx                  = IdWidth'(idx);
            end
        end
    end

    // Pointer advances past the winner only when an operation actually issues.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gidx == IdWidth'(NumReq - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Operand mux feeding the shared datapath.
    always_comb begin
        x_sel = req_x_i[gidx*WidthX +: WidthX];
        y_sel = req_y_i[gidx*WidthY +: WidthY];
        a_sel = req_a_i[gidx*WidthA +: WidthA];
    end

    mul_add_uns #(
        .WidthX (WidthX),
        .WidthY (WidthY),
        .WidthA (WidthA),
        .Speed  (Speed)
    ) u_mul_add (
        .x (x_sel),
        .y (y_sel),
        .a (a_sel),
        .p (p_sel)
    );

    // Output buffer next state: an issue always fills; a handshake alone drains.
    always_comb begin
        state_d = state_q;
        if (issue) begin
            state_d = ST_FULL;
        end else if (state_q == ST_FULL && rsp_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    // State register and pointer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Response payload and saturating issue counter; payload holds when idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_p_o     <= '0;
            rsp_id_o    <= '0;
            issue_cnt_o <= '0;
        end else if (issue) begin
            rsp_p_o  <= p_sel;
            rsp_id_o <= gidx;
            if (issue_cnt_o != 32'hFFFF_FFFF) issue_cnt_o <= issue_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_mul_add_rr_sched.sv
// Directed bench for mul_add_rr_sched with hand-computed expectations.
module tb_mul_add_rr_sched;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_ready_o;
    logic [31:0]  req_x_i;
    logic [31:0]  req_y_i;
    logic [79:0]  req_a_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [19:0]  rsp_p_o;
    logic [1:0]   rsp_id_o;
    logic         busy_o;
    logic [31:0]  issue_cnt_o;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    mul_add_rr_sched dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_x_i     (req_x_i),
        .req_y_i     (req_y_i),
        .req_a_i     (req_a_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_p_o     (rsp_p_o),
        .rsp_id_o    (rsp_id_o),
        .busy_o      (busy_o),
        .issue_cnt_o (issue_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_op(input int i, input int x, input int y, input int a);
        req_x_i[i*8 +: 8]   = 8'(x);
        req_y_i[i*8 +: 8]   = 8'(y);
        req_a_i[i*20 +: 20] = 20'(a);
    endtask

    task automatic chk_rsp(input string tag, input int id, input int p);
        chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_id"},    32'(rsp_id_o),    32'(id));
        chk({tag, "_p"},     32'(rsp_p_o),     32'(p));
        chk({tag, "_cnt"},   issue_cnt_o,      32'(exp_cnt));
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0;
        req_x_i = '0;
        req_y_i = '0;
        req_a_i = '0;
        rsp_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_p",     32'(rsp_p_o),     32'd0);
        chk("rst_id",    32'(rsp_id_o),    32'd0);
        chk("rst_cnt",   issue_cnt_o,      32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        rst_ni = 1'b1;
        tick();

        // Single request from requester 2.
        set_op(2, 200, 150, 5);
        req_valid_i = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready_o), 32'b0100);
        chk("single_busy",  32'(busy_o),      32'd1);
        tick();
        exp_cnt++;
        req_valid_i = 4'b0000;
        chk_rsp("single", 2, 30005);

        // ptr is now 3: requester 3 first, then 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_op(i, i + 1, 10, 0);
        req_valid_i = 4'b1111;
        #1;
        chk("ptr3_ready", 32'(req_ready_o), 32'b1000);
        tick();
        exp_cnt++;
        chk_rsp("ptr3", 3, 40);
        for (int e = 0; e < 5; e++) begin
            chk("rr_ready", 32'(req_ready_o), 32'(1 << (e % 4)));
            tick();
            exp_cnt++;
            chk_rsp("rr", e % 4, 10 * ((e % 4) + 1));
        end

        // Backpressure with response id 0 pending; ptr is 1.
        rsp_ready_i = 1'b0;
        #1;
        chk("bp_ready0", 32'(req_ready_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_ready", 32'(req_ready_o), 32'd0);
            chk_rsp("bp", 0, 10);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready_o), 32'b0010);
        tick();
        exp_cnt++;
        chk_rsp("bp_release", 1, 20);

        // Wraparound of the sum; ptr is 2.
        set_op(2, 255, 255, 20'hFFFFF);
        req_valid_i = 4'b0100;
        #1;
        chk("wrap_ready", 32'(req_ready_o), 32'b0100);
        tick();
        exp_cnt++;
        chk_rsp("wrap", 2, 65024);

        // Move ptr to 1, then skip to 3 and wrap to 0.
        set_op(0, 3, 4, 1);
        set_op(3, 5, 6, 7);
        req_valid_i = 4'b0001;
        tick();
        exp_cnt++;
        chk_rsp("to_ptr1", 0, 13);
        req_valid_i = 4'b1001;
        #1;
        chk("skip_ready", 32'(req_ready_o), 32'b1000);
        tick();
        exp_cnt++;
        chk_rsp("skip", 3, 37);
        chk("hold_ready", 32'(req_ready_o), 32'b0001);
        tick();
        exp_cnt++;
        chk_rsp("hold", 0, 13);

        // Drain without refill.
        req_valid_i = 4'b0000;
        tick();
        chk("drain_valid", 32'(rsp_valid_o), 32'd0);
        chk("drain_p",     32'(rsp_p_o),     32'd13);

        // Reset while a response is stalled.
        set_op(1, 2, 2, 2);
        set_op(3, 9, 9, 9);
        req_valid_i = 4'b1000;
        tick();
        exp_cnt++;
        chk_rsp("pre_rst", 3, 90);
        req_valid_i = 4'b0000;
        rsp_ready_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        exp_cnt = 0;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_p",     32'(rsp_p_o),     32'd0);
        chk("mid_rst_cnt",   issue_cnt_o,      32'd0);
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        req_valid_i = 4'b1010;
        #1;
        chk("post_rst_ready", 32'(req_ready_o), 32'b0010);
        tick();
        exp_cnt++;
        chk_rsp("post_rst", 1, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_add_rr_sched.md
Name: mul_add_rr_sched

Overview:
- Shares one combinational unsigned multiply-add datapath, P = X*Y + A, between NumReq requesters.
- Each requester has a valid/ready request channel. A round-robin arbiter issues at most one operation per cycle into the datapath.
- The result is registered, tagged with the requester index, and returned on one valid/ready response channel that supports backpressure.
- Sits between several accumulator/filter clients and a single MulAddUns instance, which this block instantiates internally.

Parameters:
- NumReq, 4, number of requesters (>= 2).
- WidthX, 8, width of each X operand (<= WidthY).
- WidthY, 8, width of each Y operand.
- WidthA, 20, width of each A operand and of the result (>= WidthX+WidthY).
- Speed, 1, performance parameter passed to the multiply-add datapath (0 slow, 1 medium, 2 fast).
- IdWidth, derived as max(1, $clog2(NumReq)), width of the response tag.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request accepted this cycle.
- req_x_i  in  NumReq*WidthX  packed X operands; requester i occupies bits [i*WidthX +: WidthX].
- req_y_i  in  NumReq*WidthY  packed Y operands, same packing.
- req_a_i  in  NumReq*WidthA  packed A operands, same packing.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_p_o  out  WidthA  result.
- rsp_id_o  out  IdWidth  index of the requester that issued the result.
- busy_o  out  1  high when rsp_valid_o is high or any req_valid_i is high.
- issue_cnt_o  out  32  count of issued operations, saturating at 2^32-1.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low; rst_ni low at a rising edge resets all state.
- Reset values: rsp_valid_o=0, rsp_p_o=0, rsp_id_o=0, issue_cnt_o=0, round-robin pointer ptr=0.
- Issue enable: issue_en = !rsp_valid_o || rsp_ready_i. This gives single-entry output buffering with a same-cycle drain-and-refill path, so there is no bubble under continuous ready.
- Arbitration:
  - The grant goes to the first i with req_valid_i[i] high, searching in order ptr, ptr+1, ... wrapping mod NumReq.
  - Grant is one-hot or zero.
  - req_ready_o[i] = issue_en && grant[i]. req_ready_o is combinational from req_valid_i, rsp_valid_o and rsp_ready_i.
- Issue event: req_valid_i[i] && req_ready_o[i]. On an issue:
  - rsp_p_o <= (X_i*Y_i + A_i) mod 2^WidthA.
  - rsp_id_o <= i.
  - rsp_valid_o <= 1.
  - ptr <= (i+1) mod NumReq.
  - issue_cnt_o increments, saturating.
- Pointer stability: ptr changes only on an issue, so a requester that was skipped keeps its priority position.
- Drain without refill: if the response handshakes (rsp_valid_o && rsp_ready_i) and there is no issue in the same cycle, rsp_valid_o <= 0. rsp_p_o and rsp_id_o hold their last value.
- Backpressure: while rsp_valid_o=1 and rsp_ready_i=0:
  - all req_ready_o=0;
  - rsp_p_o and rsp_id_o stay stable;
  - ptr is frozen.
- Latency: exactly 1 cycle from issue to rsp_valid_o under no backpressure. Sustained throughput is 1 operation per cycle.
- Fairness: with all requesters continuously valid and rsp_ready_i=1, grants rotate 0,1,...,NumReq-1,0,... Each requester waits at most NumReq-1 issues.
- Protocol rules:
  - Requesters hold req_valid_i and their operands stable until accepted. The bench asserts this.
  - The block never drops an accepted request. Each response is presented exactly once.
- Reset mid-operation: a pending response is discarded. rsp_valid_o=0 in the cycle after the reset edge, and ptr returns to 0.
- Arithmetic:
  - Unsigned throughout.
  - X*Y never exceeds WidthX+WidthY bits. The sum wraps modulo 2^WidthA (carry-out discarded).

Test Plan:
- Single request: req_valid_i=4'b0100 with X=200, Y=150, A=5 -> req_ready_o=4'b0100 that cycle. Next cycle rsp_valid_o=1, rsp_p_o=30005, rsp_id_o=2. Following that, ptr=3.
- Round robin: all four valid continuously, requester i uses X=i+1, Y=10, A=0, rsp_ready_i=1 -> ids 0,1,2,3,0,... with results 10,20,30,40,10. One response per cycle, issue_cnt_o increments each cycle.
- Backpressure: response pending with rsp_ready_i=0 for 3 cycles while all requesters are valid -> req_ready_o=0, rsp_p_o/rsp_id_o unchanged, ptr frozen. On the cycle rsp_ready_i rises, the next grant issues in the same cycle and a new response appears the following cycle.
- Wrap: X=255, Y=255, A=2^20-1 with WidthA=20 -> rsp_p_o=65024, i.e. (65025+1048575) mod 2^20.
- Skip with priority hold: ptr=1, req_valid_i=4'b1001 -> requester 3 is granted and ptr becomes 0. Next cycle, with req_valid_i=4'b1001, requester 0 is granted.
- Reset mid-operation: rst_ni=0 while rsp_valid_o=1 and rsp_ready_i=0 -> after the edge rsp_valid_o=0, rsp_p_o=0, issue_cnt_o=0. The first post-reset grant goes to the lowest valid index.
